// File: rtl/canny_pkg.sv
// Shared encodings and geometry for the Canny stage sequencer and its address generator.
package canny_pkg;

  localparam int CANNY_IMG_DIM = 20;
  localparam int CANNY_ADDR_W  = 9;

  typedef enum logic [2:0] {
    OP_IDLE = 3'd0,
    OP_MED  = 3'd1,
    OP_GAU  = 3'd2,
    OP_SOB  = 3'd3,
    OP_NMX  = 3'd4,
    OP_HYS  = 3'd5
  } op_e;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETOP = 3'd1;
  localparam logic [2:0] ST_SCAN  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_WB    = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Gaussian is the only 5x5 kernel; everything else is 3x3.
  function automatic logic [2:0] k_of(input logic [2:0] op);
    return (op == OP_GAU) ? 3'd5 : 3'd3;
  endfunction

  function automatic logic [2:0] h_of(input logic [2:0] op);
    return (k_of(op) - 3'd1) >> 1;
  endfunction

endpackage

// File: rtl/canny_raster_addr_gen.sv
// Combinational raster addressing: column taps for rows r..r+K-1 and the NON_MAX angle index.
module canny_raster_addr_gen #(
  parameter int IMG_DIM = 20,
  parameter int ADDR_W  = 9,
  parameter int CW      = $clog2(IMG_DIM)
) (
  input  logic [CW-1:0]     r_i,
  input  logic [CW-1:0]     c_i,
  input  logic [2:0]        k_i,
  output logic [ADDR_W-1:0] rd_addr0_o,
  output logic [ADDR_W-1:0] rd_addr1_o,
  output logic [ADDR_W-1:0] rd_addr2_o,
  output logic [ADDR_W-1:0] rd_addr3_o,
  output logic [ADDR_W-1:0] rd_addr4_o,
  output logic [ADDR_W-1:0] ang_addr_o
);

  logic [ADDR_W-1:0] tap [5];

  // Taps beyond the kernel height are parked at 0.
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      tap[k] = (k < int'(k_i)) ? ADDR_W'((int'(r_i) + k) * IMG_DIM + int'(c_i)) : '0;
    end
    ang_addr_o = (c_i != '0) ? ADDR_W'((int'(r_i) + 1) * IMG_DIM + int'(c_i) - 1) : '0;
  end

  assign rd_addr0_o = tap[0];
  assign rd_addr1_o = tap[1];
  assign rd_addr2_o = tap[2];
  assign rd_addr3_o = tap[3];
  assign rd_addr4_o = tap[4];

endmodule

// File: rtl/canny_stage_sequencer.sv
// Sequences MED, GAU, SOBEL, NON_MAX and HYSTER over the image file: window scan,
// in-flight tracking, tmp write pointer and border write-back handshake.
module canny_stage_sequencer
  import canny_pkg::*;
#(
  parameter int IMG_DIM = CANNY_IMG_DIM,
  parameter int ADDR_W  = CANNY_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_end,
  output logic [2:0]        op,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  output logic [ADDR_W-1:0] rd_addr3,
  output logic [ADDR_W-1:0] rd_addr4,
  output logic [ADDR_W-1:0] ang_addr,
  output logic              win_en,
  input  logic              out_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wb_req,
  input  logic              wb_done,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(IMG_DIM);

  logic [2:0]        state_q, state_d, op_q, op_d, pend_q, pend_d;
  logic [CW-1:0]     r_q, r_d, c_q, c_d, wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              err_q, err_d, win_q, accept;
  logic [2:0]        k, h;
  logic [ADDR_W-1:0] rd0_q, rd1_q, rd2_q, rd3_q, rd4_q, ang_q;
  logic [ADDR_W-1:0] rd0_n, rd1_n, rd2_n, rd3_n, rd4_n, ang_n;

  assign k      = k_of(op_q);
  assign h      = h_of(op_q);
  assign accept = out_valid && (pend_q != 3'd0);

  // Addresses are computed for the coming scan column so they register alongside it.
  canny_raster_addr_gen #(.IMG_DIM(IMG_DIM), .ADDR_W(ADDR_W), .CW(CW)) u_addr (
    .r_i(r_d), .c_i(c_d), .k_i(k),
    .rd_addr0_o(rd0_n), .rd_addr1_o(rd1_n), .rd_addr2_o(rd2_n),
    .rd_addr3_o(rd3_n), .rd_addr4_o(rd4_n), .ang_addr_o(ang_n)
  );

  always_comb begin
    pend_d = pend_q;
    if (win_q && !accept && pend_q != 3'd7) pend_d = pend_q + 3'd1;
    else if (!win_q && accept)               pend_d = pend_q - 3'd1;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    r_d     = r_q;
    c_d     = c_q;
    case (state_q)
      ST_IDLE:  if (load_end) begin state_d = ST_SETOP; op_d = OP_MED; end
      ST_SETOP: begin state_d = ST_SCAN; r_d = '0; c_d = '0; end
      ST_SCAN: begin
        if (int'(c_q) == IMG_DIM - 1) state_d = ST_DRAIN;
        else                          c_d = c_q + CW'(1);
      end
      ST_DRAIN: begin
        if (pend_d == 3'd0) begin
          if (int'(r_q) < IMG_DIM - int'(k)) begin
            state_d = ST_SCAN; r_d = r_q + CW'(1); c_d = '0;
          end else begin
            state_d = (op_q == OP_HYS) ? ST_DONE : ST_WB;
          end
        end
      end
      ST_WB:   if (wb_done) begin state_d = ST_SETOP; op_d = op_q + 3'd1; end
      ST_DONE: begin state_d = ST_IDLE; op_d = OP_IDLE; end
      default: state_d = ST_IDLE;
    endcase
  end

  // The pointer skips 2h border pixels after every full row of results.
  always_comb begin
    ptr_d  = ptr_q;
    wcnt_d = wcnt_q;
    if (state_q == ST_SETOP) begin
      ptr_d  = ADDR_W'(int'(h) * IMG_DIM + int'(h));
      wcnt_d = '0;
    end else if (accept) begin
      if (int'(wcnt_q) == IMG_DIM - int'(k)) begin
        ptr_d  = ptr_q + ADDR_W'(2 * int'(h) + 1);
        wcnt_d = '0;
      end else begin
        ptr_d  = ptr_q + ADDR_W'(1);
        wcnt_d = wcnt_q + CW'(1);
      end
    end
    err_d = err_q | (out_valid && pend_q == 3'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_IDLE;
      r_q     <= '0;
      c_q     <= '0;
      pend_q  <= '0;
      ptr_q   <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      win_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      rd3_q   <= '0;
      rd4_q   <= '0;
      ang_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      r_q     <= r_d;
      c_q     <= c_d;
      pend_q  <= pend_d;
      ptr_q   <= ptr_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      win_q   <= (state_d == ST_SCAN) && (int'(c_d) >= int'(k) - 1);
      if (state_d == ST_SCAN) begin
        rd0_q <= rd0_n;
        rd1_q <= rd1_n;
        rd2_q <= rd2_n;
        rd3_q <= rd3_n;
        rd4_q <= rd4_n;
        ang_q <= ang_n;
      end
    end
  end

  assign op       = op_q;
  assign rd_addr0 = rd0_q;
  assign rd_addr1 = rd1_q;
  assign rd_addr2 = rd2_q;
  assign rd_addr3 = rd3_q;
  assign rd_addr4 = rd4_q;
  assign ang_addr = ang_q;
  assign win_en   = win_q;
  assign wr_en    = accept;
  assign wr_addr  = ptr_q;
  assign wb_req   = (state_q == ST_WB);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign err      = err_q;

endmodule

// File: tb/tb_canny_stage_sequencer.sv
// Bench for canny_stage_sequencer: random-latency filter model, window/write scoreboards.
module tb_canny_stage_sequencer;

  logic       clk = 1'b0;
  logic       reset, load_end, out_valid, wb_done;
  logic [2:0] op;
  logic [8:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3, rd_addr4, ang_addr, wr_addr;
  logic       win_en, wr_en, wb_req, busy, done, err;

  canny_stage_sequencer dut (
    .clk(clk), .reset(reset), .load_end(load_end), .op(op),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_addr3(rd_addr3), .rd_addr4(rd_addr4), .ang_addr(ang_addr),
    .win_en(win_en), .out_valid(out_valid), .wr_en(wr_en), .wr_addr(wr_addr),
    .wb_req(wb_req), .wb_done(wb_done), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  int lat, K, H, N, exp_op, nwr, outstanding, start_cyc, first_win, last_wr, exp_err;
  bit mon_on, row_end_pend, row_end_final;
  int dueq[$], wq[$], winr[$], winc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic monitor();
    logic [8:0] taps [5];
    int r, c;
    if (!mon_on) return;
    chk("op", op, exp_op);
    chk("busy", busy, 1);
    chk("err", err, exp_err);
    chk("wb_req", wb_req, row_end_pend && row_end_final && exp_op != 5);
    chk("done", done, row_end_pend && row_end_final && exp_op == 5);
    if (row_end_pend && !row_end_final) begin
      chk("drain_exit_rd0", rd_addr0, (nwr / N) * 20);
      chk("drain_exit_win", win_en, 0);
    end
    row_end_pend = 0;
    if (cyc == start_cyc + 2) begin
      chk("scan0_rd0", rd_addr0, 0);
      chk("scan0_rd1", rd_addr1, 20);
      chk("scan0_rd2", rd_addr2, 40);
      if (K == 5) chk("scan0_rd4", rd_addr4, 80);
      chk("scan0_win", win_en, 0);
    end
    chk("wr_en", wr_en, out_valid && outstanding > 0);
    if (wr_en) begin
      chk("wr_extra", wq.size() > 0, 1);
      if (wq.size() > 0) chk("wr_addr", wr_addr, wq.pop_front());
      nwr++;
      outstanding--;
      last_wr = wr_addr;
      if (nwr % N == 0) begin
        row_end_pend  = 1;
        row_end_final = (nwr == N * N);
      end
    end
    if (win_en) begin
      if (first_win < 0) begin
        first_win = cyc;
        chk("first_win", cyc - start_cyc, K + 1);
      end
      chk("win_extra", winr.size() > 0, 1);
      if (winr.size() > 0) begin
        r = winr.pop_front();
        c = winc.pop_front();
        taps = '{rd_addr0, rd_addr1, rd_addr2, rd_addr3, rd_addr4};
        for (int k = 0; k < K; k++) chk("rd_tap", taps[k], (r + k) * 20 + c);
        if (exp_op == 4) chk("ang_addr", ang_addr, (r + 1) * 20 + c - 1);
      end
      outstanding++;
      dueq.push_back(cyc + lat);
    end
  endtask

  task automatic tick(input logic lend, input logic wbd, input logic force_ov);
    @(negedge clk);
    load_end  = lend;
    wb_done   = wbd;
    out_valid = force_ov;
    if (dueq.size() > 0 && dueq[0] == cyc) begin
      out_valid = 1'b1;
      void'(dueq.pop_front());
    end
    #1;
    monitor();
    cyc++;
  endtask

  task automatic op_begin(input int o);
    K = (o == 2) ? 5 : 3;
    H = (K - 1) / 2;
    N = 20 - K + 1;
    lat = $urandom_range(1, 6);
    nwr = 0; outstanding = 0; first_win = -1; row_end_pend = 0; row_end_final = 0;
    dueq.delete(); wq.delete(); winr.delete(); winc.delete();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) wq.push_back((H + i) * 20 + H + j);
    for (int r = 0; r <= 20 - K; r++)
      for (int c = K - 1; c < 20; c++) begin winr.push_back(r); winc.push_back(c); end
    mon_on = 0;
    start_cyc = cyc;
    if (o == 1) tick(1, 0, 0);
    else begin
      tick(0, 1, 0);
      chk("wb_req_at_done", wb_req, 1);
    end
    exp_op = o;
    mon_on = 1;
  endtask

  task automatic op_finish(input int inj_l, input int inj_w);
    int guard = 0;
    do begin
      tick(cyc == inj_l, cyc == inj_w, 0);
      guard++;
    end while (!(wb_req || done) && guard < 3000);
    chk("op_timeout", guard < 3000, 1);
    mon_on = 0;
    chk("n_writes", nwr, (K == 3) ? 324 : 256);
    chk("last_wr", last_wr, (K == 3) ? 378 : 357);
    chk("wins_left", winr.size(), 0);
    chk("outstanding", outstanding, 0);
  endtask

  task automatic wb_wait();
    repeat ($urandom_range(0, 3)) begin
      tick(0, 0, 0);
      chk("wb_req_hold", wb_req, 1);
      chk("wb_op", op, exp_op);
    end
  endtask

  initial begin
    reset = 1'b0; load_end = 1'b0; out_valid = 1'b0; wb_done = 1'b0;
    mon_on = 0; exp_err = 0;
    repeat (3) tick(0, 0, 0);
    chk("rst_op", op, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wb_req", wb_req, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_err", err, 0);
    chk("rst_win_en", win_en, 0);
    chk("rst_rd0", rd_addr0, 0);
    chk("rst_wr_addr", wr_addr, 0);
    reset = 1'b1;
    tick(0, 0, 0);
    chk("idle_op", op, 0);

    // Stray out_valid while idle sets err; reset mid-scan must clear it.
    tick(0, 0, 1);
    chk("idle_ov_wr", wr_en, 0);
    tick(0, 0, 0);
    chk("idle_err", err, 1);
    exp_err = 1;
    op_begin(1);
    repeat (12) tick(0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    out_valid = 1'b0;
    #1;
    mon_on = 0;
    chk("abort_op", op, 0);
    chk("abort_busy", busy, 0);
    chk("abort_wr_en", wr_en, 0);
    chk("abort_err", err, 0);
    chk("abort_win", win_en, 0);
    chk("abort_wb_req", wb_req, 0);
    exp_err = 0;
    dueq.delete();
    @(negedge clk);
    reset = 1'b1;

    // Full five-stage run with stray load_end and wb_done pulses.
    op_begin(1); op_finish(-1, -1); wb_wait();
    op_begin(2); op_finish(start_cyc + $urandom_range(5, 200), -1); wb_wait();
    op_begin(3); op_finish(-1, start_cyc + $urandom_range(5, 200)); wb_wait();
    op_begin(4); op_finish(-1, -1); wb_wait();
    op_begin(5); op_finish(-1, -1);
    chk("done_pulse", done, 1);
    chk("hys_no_wb", wb_req, 0);
    tick(0, 0, 0);
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_op", op, 0);
    chk("post_wb_req", wb_req, 0);
    repeat (3) begin
      tick(0, 0, 0);
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
    end

    // out_valid during write-back is an error; load_end while busy is ignored.
    op_begin(1); op_finish(-1, -1);
    tick(0, 0, 1);
    chk("wb_ov_wr", wr_en, 0);
    chk("wb_ov_req", wb_req, 1);
    tick(0, 0, 0);
    chk("wb_err", err, 1);
    exp_err = 1;
    tick(1, 0, 0);
    tick(0, 0, 0);
    chk("busy_load_op", op, 1);
    chk("busy_load_wb", wb_req, 1);
    op_begin(2); op_finish(-1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
